// File: rtl/keccak_x_heep_pkg.sv
// keccak_x_heep_pkg: shared constants, register map and bus types for the Keccak accelerator
package keccak_x_heep_pkg;
  localparam int NUM_WORDS = 50;
  localparam int KECCAK_STATE_W = 1600;
  localparam logic [8:0] DIN_OFFSET = 9'h000;
  localparam logic [8:0] CTRL_OFFSET = 9'h0C8;
  localparam logic [8:0] STATUS_OFFSET = 9'h0CC;
  localparam logic [8:0] INTR_EN_OFFSET = 9'h0D0;
  localparam logic [8:0] DOUT_BASE = 9'h100;
  localparam logic [8:0] DOUT_OFFSET = DOUT_BASE;
  localparam logic [8:0] WIN_BYTES = 9'(NUM_WORDS * 4);
  typedef enum logic [1:0] {IDLE, KICK, WAIT} ctrl_state_e;
  typedef enum logic [2:0] {RG_DIN, RG_CTRL, RG_STATUS, RG_INTR_EN, RG_DOUT, RG_NONE} region_e;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

// File: rtl/keccak_reg_decode.sv
// keccak_reg_decode: maps a byte offset to a register region, word index and decode error
module keccak_reg_decode
  import keccak_x_heep_pkg::*;
(
  input  logic [8:0] addr,
  output region_e    region,
  output logic [5:0] idx,
  output logic       err
);
  logic din, dout;
  always_comb begin
    din = addr < DIN_OFFSET + WIN_BYTES;
    dout = addr >= DOUT_OFFSET && addr < DOUT_OFFSET + WIN_BYTES;
    idx = 6'((addr - (dout ? DOUT_OFFSET : DIN_OFFSET)) >> 2);
    region = addr[1:0] != 2'b00 ? RG_NONE :
             din ? RG_DIN :
             addr == CTRL_OFFSET ? RG_CTRL :
             addr == STATUS_OFFSET ? RG_STATUS :
             addr == INTR_EN_OFFSET ? RG_INTR_EN :
             dout ? RG_DOUT : RG_NONE;
    err = region == RG_NONE;
  end
endmodule

// File: rtl/keccak_reg_ctrl.sv
// keccak_reg_ctrl: reg-bus front-end holding Keccak input/output state and sequencing the core
module keccak_reg_ctrl
  import keccak_x_heep_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  reg_req_t                  reg_req_i,
  output reg_rsp_t                  reg_rsp_o,
  output logic                      core_start_o,
  output logic [KECCAK_STATE_W-1:0] core_din_o,
  input  logic                      core_done_i,
  input  logic [KECCAK_STATE_W-1:0] core_dout_i,
  output logic                      intr_o
);
  ctrl_state_e state_q, state_d;
  logic [31:0] din_q [NUM_WORDS];
  logic [31:0] dout_q [NUM_WORDS];
  logic done_q, ie_q, busy, dec_err, err, wr_ok, start, clr, capture, unused_addr;
  region_e region;
  logic [5:0] idx;
  keccak_reg_decode u_dec (
    .addr   (reg_req_i.addr[8:0]),
    .region (region),
    .idx    (idx),
    .err    (dec_err)
  );
  assign unused_addr = ^reg_req_i.addr[31:9];
  assign busy = state_q != IDLE;
  assign err = dec_err | (reg_req_i.write & (region == RG_DOUT | (region == RG_DIN & busy)));
  assign wr_ok = reg_req_i.valid & reg_req_i.write & ~err;
  assign start = wr_ok & region == RG_CTRL & reg_req_i.wdata[0] & ~busy;
  assign clr = wr_ok & region == RG_STATUS & reg_req_i.wdata[1];
  assign capture = state_q == WAIT & core_done_i;
  assign core_start_o = state_q == KICK;
  assign intr_o = done_q & ie_q;
  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_din
    assign core_din_o[32*i +: 32] = din_q[i];
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? KICK : IDLE) :
              state_q == KICK ? WAIT :
              capture ? IDLE : WAIT;
  end
  always_comb begin
    reg_rsp_o.ready = reg_req_i.valid;
    reg_rsp_o.error = reg_req_i.valid & err;
    reg_rsp_o.rdata = (!reg_req_i.valid || reg_req_i.write || err) ? 32'h0 :
                      region == RG_DIN ? din_q[idx] :
                      region == RG_DOUT ? dout_q[idx] :
                      region == RG_STATUS ? {30'h0, done_q, busy} :
                      region == RG_INTR_EN ? {31'h0, ie_q} : 32'h0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      done_q <= 1'b0;
      ie_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= capture | (done_q & ~start & ~clr);
      if (wr_ok && region == RG_INTR_EN && reg_req_i.wstrb[0]) ie_q <= reg_req_i.wdata[0];
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_WORDS; k++) din_q[k] <= 32'h0;
    end else if (wr_ok && region == RG_DIN) begin
      for (int b = 0; b < 4; b++)
        if (reg_req_i.wstrb[b]) din_q[idx][8*b +: 8] <= reg_req_i.wdata[8*b +: 8];
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_WORDS; k++) dout_q[k] <= 32'h0;
    end else if (capture) begin
      for (int k = 0; k < NUM_WORDS; k++) dout_q[k] <= core_dout_i[32*k +: 32];
    end
  end
endmodule

// File: doc/keccak_reg_ctrl.md
# keccak_reg_ctrl

Register-bus front-end of the Keccak accelerator, placed between the peripheral reg bus of the X-HEEP system and the Keccak-f[1600] permutation core. It holds the 1600-bit input state written by software, starts the core, waits for completion and captures the 1600-bit output state. It also drives the accelerator's completion interrupt into the external interrupt vector.

## Interface
- NUM_WORDS, 50: 32-bit words per 1600-bit state.
- DOUT_BASE, 0x100: byte offset of the output window.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- reg_req_i  in  reg_req_t  reg bus request (addr, write, wdata, wstrb, valid).
- reg_rsp_o  out  reg_rsp_t  reg bus response (rdata, error, ready).
- core_start_o  out  1  one-cycle start pulse to the permutation core.
- core_din_o  out  1600  input state; word i maps to bits [32i+31:32i].
- core_done_i  in  1  one-cycle completion pulse from the core.
- core_dout_i  in  1600  output state, valid in the cycle core_done_i is high.
- intr_o  out  1  level interrupt, drives external interrupt line 0.

## Operation
- Byte-offset map (addr[8:0], word aligned):
  - 0x000–0x0C4: DIN[0..49], read/write.
  - 0x0C8: CTRL. Writing 1 to bit0 = START; reads 0.
  - 0x0CC: STATUS. bit0 BUSY (read-only); bit1 DONE (sticky; write-1-to-clear).
  - 0x0D0: INTR_EN. bit0, read/write.
  - DOUT_BASE + 0x000–0x0C4: DOUT[0..49], read-only.
- wstrb applies per byte to DIN and INTR_EN.
- Any other offset, any write to DOUT, or any DIN write while BUSY: no state change, error=1.
- FSM with three states:
  - IDLE: START write → KICK. DONE is cleared in the same cycle.
  - KICK: core_start_o=1 for exactly one cycle → WAIT.
  - WAIT: core_done_i → capture core_dout_i into DOUT, set DONE → IDLE.
- BUSY = (state != IDLE).
- START write while BUSY: ignored, error=0.
- core_done_i outside WAIT: ignored.
- intr_o = DONE & INTR_EN[0].
- core_din_o is driven directly from the DIN registers, which stay stable during BUSY.

## Timing
- Reg bus is single-cycle: ready = valid. rdata and error are combinational from the current request. rdata is 0 when error=1 or on a write.
- Reset values: all outputs 0; DIN, DOUT, INTR_EN, DONE all 0; state IDLE.
- START accepted in cycle T:
  - core_start_o high in T+1.
  - BUSY reads 1 from T+1.
- core_done_i high in cycle D:
  - DOUT and DONE updated at the D+1 edge.
  - BUSY reads 0 and intr_o rises in D+1.
- Same-cycle write-1-to-clear DONE and core_done_i: set wins.
- Reset mid-operation: returns to IDLE immediately. A later core_done_i is ignored.
- Read of DOUT in the same cycle as capture returns the old value.

## Structure
- keccak_x_heep_pkg gains:
  - the offset constants (DIN_OFFSET, CTRL_OFFSET, STATUS_OFFSET, INTR_EN_OFFSET, DOUT_OFFSET);
  - the ctrl_state_e enum {IDLE, KICK, WAIT};
  - KECCAK_STATE_W = 1600.
- One sub-module, keccak_reg_decode: combinational address decode producing a word index, a region select and an error flag. Used for both read and write paths.
- FSM, DIN/DOUT register files and interrupt logic live in keccak_reg_ctrl.

## Test plan
- Reset: assert rst_i mid-cycle → all outputs 0; STATUS reads 0x0; DIN[0] reads 0x0.
- Full run:
  - write DIN[i]=i for all i, set INTR_EN=1, START;
  - core model returns done after 24 cycles with dout=~din;
  - required: core_start_o one pulse, BUSY=1 during the run, DOUT[5]=0xFFFFFFFA, intr_o=1.
  - Then write 0x2 to STATUS → intr_o=0.
- Busy protection: during WAIT, write DIN[3]=0xDEADBEEF → error=1, DIN[3] unchanged. A second START produces no second start pulse.
- Errors: write DOUT[0] → error=1. Read offset 0x0D4 → error=1, rdata=0. Write DIN[1] with wstrb=0b0010, wdata=0xAABBCCDD → DIN[1]=0x0000CC00 from reset.
- Race: core_done_i in the same cycle as a write of 0x2 to STATUS → DONE reads 1 afterwards.
- Reset during WAIT, then core_done_i pulse → DONE=0, DOUT unchanged, intr_o=0.
